// File: rtl/rr_mux412_arbiter.sv
// rr_mux412_arbiter: round-robin arbiter that shares one output channel
// between four requesters through a 4:1 mux. It owns select sequencing,
// the valid/ready handshake and burst-length fairness.
module rr_mux412_arbiter #(
  parameter int DATA_LEN  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req_valid,
  input  logic [DATA_LEN-1:0] req_data0,
  input  logic [DATA_LEN-1:0] req_data1,
  input  logic [DATA_LEN-1:0] req_data2,
  input  logic [DATA_LEN-1:0] req_data3,
  output logic [3:0]          req_ready,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  input  logic                out_ready,
  output logic [1:0]          out_sel,
  output logic                busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Beat count at which an accepted beat closes the current grant.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t              r_state;
  logic [1:0]          r_out_sel;
  logic [1:0]          r_last_grant;
  logic [3:0]          r_beat_cnt;

  logic [1:0]          w_winner;
  logic [DATA_LEN-1:0] w_mux_data;
  logic                w_xfer;
  logic                w_release;

  // Rotating-priority pick: first valid requester after the last grant.
  // Scanning from the farthest candidate back keeps the closest one.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] valid);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (valid[cand]) begin
        pick = cand;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Winner selection for the next grant.
  always_comb begin
    w_winner = rr_pick(r_last_grant, req_valid);
  end

  // The 4:1 datapath mux, steered by the registered grant index.
  always_comb begin
    w_mux_data = '0;
    case (r_out_sel)
      2'd0:    w_mux_data = req_data0;
      2'd1:    w_mux_data = req_data1;
      2'd2:    w_mux_data = req_data2;
      2'd3:    w_mux_data = req_data3;
      default: w_mux_data = req_data0;
    endcase
  end

  // Handshake outputs: pass-through of the granted port while busy, quiet otherwise.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    req_ready = 4'b0000;
    busy      = 1'b0;
    if (r_state == ST_BUSY) begin
      out_valid            = req_valid[r_out_sel];
      out_data             = w_mux_data;
      req_ready[r_out_sel] = out_ready;
      busy                 = 1'b1;
    end else begin
      out_valid = 1'b0;
      out_data  = '0;
      req_ready = 4'b0000;
      busy      = 1'b0;
    end
  end

  // Transfer and release conditions for the held grant. A dropped valid
  // releases at once; a full burst releases only on an accepted beat.
  always_comb begin
    w_xfer    = (r_state == ST_BUSY) && req_valid[r_out_sel] && out_ready;
    w_release = (!req_valid[r_out_sel]) || (w_xfer && (r_beat_cnt == BURST_LAST));
  end

  assign out_sel = r_out_sel;

  // Grant FSM: IDLE picks a winner, BUSY holds it until burst end or valid drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_out_sel    <= 2'b00;
      r_last_grant <= 2'b11;
      r_beat_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_out_sel  <= w_winner;
            r_beat_cnt <= 4'd0;
            r_state    <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_last_grant <= r_out_sel;
            r_beat_cnt   <= 4'd0;
            r_state      <= ST_IDLE;
          end else if (w_xfer && (r_beat_cnt != 4'hF)) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
          end else begin
            r_beat_cnt <= r_beat_cnt;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_beat_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux412_arbiter.sv
// Self-checking bench for rr_mux412_arbiter: default build (MAX_BURST=4)
// plus a MAX_BURST=1 build. Accepted beats are checked against a queue of
// expected (grant index, data) pairs filled when stimulus is set up.
module tb_rr_mux412_arbiter;

  typedef struct packed {
    logic [1:0] sel;
    logic [1:0] data;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [1:0] d [4];
  logic       out_ready;
  logic [3:0] req_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic [1:0] out_sel;
  logic       busy;

  logic       b_rst_n;
  logic [3:0] b_req_valid;
  logic [3:0] b_req_ready;
  logic       b_out_valid;
  logic [1:0] b_out_data;
  logic [1:0] b_out_sel;
  logic       b_busy;

  beat_t sb_q[$];
  beat_t exp_b;
  int    n_checks;
  int    n_errors;

  rr_mux412_arbiter #(.DATA_LEN(2), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_data0(d[0]), .req_data1(d[1]), .req_data2(d[2]), .req_data3(d[3]),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_sel(out_sel), .busy(busy)
  );

  rr_mux412_arbiter #(.DATA_LEN(2), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid),
    .req_data0(d[0]), .req_data1(d[1]), .req_data2(d[2]), .req_data3(d[3]),
    .req_ready(b_req_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(out_ready), .out_sel(b_out_sel), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset the main DUT with the given inputs; leaves us 1 time unit after
  // the edge at which reset was released (start of cycle 0).
  task automatic apply_reset(input logic [3:0] v, input logic rdy);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = v;
    out_ready = rdy;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0000 || out_data !== 2'b00 || out_sel !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_outputs: busy=%b valid=%b ready=%b data=%b sel=%b, want all zero",
               busy, out_valid, req_ready, out_data, out_sel);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_held: busy=%b valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_single();
    d[0] = 2'b10; d[1] = 2'b01; d[2] = 2'b11; d[3] = 2'b00;
    for (int i = 0; i < 5; i++) sb_q.push_back('{sel: 2'd0, data: 2'b10});
    apply_reset(4'b0001, 1'b1);
    for (int c = 0; c < 7; c++) begin
      logic exp_busy;
      exp_busy = (c != 0) && (c != 5);
      @(negedge clk);
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++;
        $display("FAIL single_busy c=%0d: got %b want %b", c, busy, exp_busy);
      end
      if (exp_busy) begin
        n_checks++;
        if (out_sel !== 2'd0 || req_ready !== 4'b0001) begin
          n_errors++;
          $display("FAIL single_grant c=%0d: sel=%0d ready=%b want 0 0001", c, out_sel, req_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL single_extra_beat c=%0d: sel=%0d data=%b", c, out_sel, out_data);
        end else begin
          exp_b = sb_q.pop_front();
          if (out_sel !== exp_b.sel || out_data !== exp_b.data) begin
            n_errors++;
            $display("FAIL single_beat c=%0d: sel=%0d data=%b want sel=%0d data=%b",
                     c, out_sel, out_data, exp_b.sel, exp_b.data);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL single_missing: %0d beats left, want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_round_robin();
    d[0] = 2'b01; d[1] = 2'b10; d[2] = 2'b11; d[3] = 2'b00;
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 4; b++)
        sb_q.push_back('{sel: 2'(g % 4), data: d[g % 4]});
    apply_reset(4'b1111, 1'b1);
    for (int c = 0; c < 25; c++) begin
      logic       exp_busy;
      logic [1:0] exp_sel;
      exp_busy = (c % 5) != 0;
      exp_sel  = 2'((c / 5) % 4);
      @(negedge clk);
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++;
        $display("FAIL rr_busy c=%0d: got %b want %b", c, busy, exp_busy);
      end
      if (exp_busy) begin
        n_checks++;
        if (out_sel !== exp_sel || req_ready !== (4'b0001 << exp_sel)) begin
          n_errors++;
          $display("FAIL rr_grant c=%0d: sel=%0d ready=%b want sel=%0d", c, out_sel, req_ready, exp_sel);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL rr_extra_beat c=%0d: sel=%0d data=%b", c, out_sel, out_data);
        end else begin
          exp_b = sb_q.pop_front();
          if (out_sel !== exp_b.sel || out_data !== exp_b.data) begin
            n_errors++;
            $display("FAIL rr_beat c=%0d: sel=%0d data=%b want sel=%0d data=%b",
                     c, out_sel, out_data, exp_b.sel, exp_b.data);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL rr_missing: %0d beats left, want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_stall();
    d[2] = 2'b11;
    for (int i = 0; i < 4; i++) sb_q.push_back('{sel: 2'd2, data: 2'b11});
    apply_reset(4'b0100, 1'b0);
    for (int c = 0; c < 9; c++) begin
      logic exp_busy;
      out_ready = (c >= 4);
      exp_busy  = (c >= 1) && (c <= 7);
      @(negedge clk);
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++;
        $display("FAIL stall_busy c=%0d: got %b want %b", c, busy, exp_busy);
      end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || req_ready !== 4'b0000 || out_sel !== 2'd2) begin
          n_errors++;
          $display("FAIL stall_hold c=%0d: valid=%b ready=%b sel=%0d want 1 0000 2",
                   c, out_valid, req_ready, out_sel);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL stall_extra_beat c=%0d: sel=%0d data=%b", c, out_sel, out_data);
        end else begin
          exp_b = sb_q.pop_front();
          if (out_sel !== exp_b.sel || out_data !== exp_b.data) begin
            n_errors++;
            $display("FAIL stall_beat c=%0d: sel=%0d data=%b want sel=%0d data=%b",
                     c, out_sel, out_data, exp_b.sel, exp_b.data);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL stall_missing: %0d beats left, want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_drop();
    d[1] = 2'b01; d[3] = 2'b10;
    sb_q.push_back('{sel: 2'd1, data: 2'b01});
    sb_q.push_back('{sel: 2'd1, data: 2'b01});
    sb_q.push_back('{sel: 2'd3, data: 2'b10});
    apply_reset(4'b1010, 1'b1);
    for (int c = 0; c < 6; c++) begin
      logic exp_busy;
      if (c == 3) req_valid = 4'b1000;
      exp_busy = (c != 0) && (c != 4);
      @(negedge clk);
      n_checks++;
      if (busy !== exp_busy) begin
        n_errors++;
        $display("FAIL drop_busy c=%0d: got %b want %b", c, busy, exp_busy);
      end
      if (c == 3) begin
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd1) begin
          n_errors++;
          $display("FAIL drop_idle_beat: valid=%b sel=%0d want 0 1", out_valid, out_sel);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (out_sel !== 2'd1) begin
          n_errors++;
          $display("FAIL drop_sel_hold: sel=%0d want 1", out_sel);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL drop_extra_beat c=%0d: sel=%0d data=%b", c, out_sel, out_data);
        end else begin
          exp_b = sb_q.pop_front();
          if (out_sel !== exp_b.sel || out_data !== exp_b.data) begin
            n_errors++;
            $display("FAIL drop_beat c=%0d: sel=%0d data=%b want sel=%0d data=%b",
                     c, out_sel, out_data, exp_b.sel, exp_b.data);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drop_missing: %0d beats left, want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_midburst_reset();
    d[2] = 2'b11;
    sb_q.push_back('{sel: 2'd2, data: 2'b11});
    sb_q.push_back('{sel: 2'd2, data: 2'b11});
    apply_reset(4'b0100, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0000 || out_sel !== 2'b00) begin
          n_errors++;
          $display("FAIL midreset_outputs: busy=%b valid=%b ready=%b sel=%0d want 0 0 0000 0",
                   busy, out_valid, req_ready, out_sel);
        end
      end
      if (c == 3) rst_n = 1'b1;
      @(negedge clk);
      if (c == 4) begin
        n_checks++;
        if (busy !== 1'b1 || out_sel !== 2'd2) begin
          n_errors++;
          $display("FAIL midreset_regrant: busy=%b sel=%0d want 1 2", busy, out_sel);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL midreset_extra_beat c=%0d: sel=%0d data=%b", c, out_sel, out_data);
        end else begin
          exp_b = sb_q.pop_front();
          if (out_sel !== exp_b.sel || out_data !== exp_b.data) begin
            n_errors++;
            $display("FAIL midreset_beat c=%0d: sel=%0d data=%b want sel=%0d data=%b",
                     c, out_sel, out_data, exp_b.sel, exp_b.data);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL midreset_missing: %0d beats left, want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_burst1();
    d[0] = 2'b01; d[2] = 2'b10;
    for (int i = 0; i < 4; i++)
      sb_q.push_back('{sel: (i % 2 == 0) ? 2'd0 : 2'd2, data: (i % 2 == 0) ? 2'b01 : 2'b10});
    @(posedge clk); #1;
    b_rst_n     = 1'b0;
    b_req_valid = 4'b0101;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic exp_busy;
      exp_busy = (c % 2) == 1;
      @(negedge clk);
      n_checks++;
      if (b_busy !== exp_busy) begin
        n_errors++;
        $display("FAIL b1_busy c=%0d: got %b want %b", c, b_busy, exp_busy);
      end
      if (b_out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL b1_extra_beat c=%0d: sel=%0d data=%b", c, b_out_sel, b_out_data);
        end else begin
          exp_b = sb_q.pop_front();
          if (b_out_sel !== exp_b.sel || b_out_data !== exp_b.data) begin
            n_errors++;
            $display("FAIL b1_beat c=%0d: sel=%0d data=%b want sel=%0d data=%b",
                     c, b_out_sel, b_out_data, exp_b.sel, exp_b.data);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL b1_missing: %0d beats left, want 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    b_rst_n     = 1'b0;
    req_valid   = 4'b0000;
    b_req_valid = 4'b0000;
    out_ready   = 1'b0;
    d[0] = 2'b00; d[1] = 2'b00; d[2] = 2'b00; d[3] = 2'b00;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_midburst_reset();
    test_burst1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_mux412_arbiter.md
Name: rr_mux412_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 2-bit output channel between four 2-bit requesters.
- Internally it drives the select of a 4:1 2-bit mux (the mux412 datapath: X0..X3, Y, F).
- It owns select sequencing, the valid/ready handshake and burst-length fairness.
- Sits between four producer blocks and a single consumer.

Parameters:
- DATA_LEN, 2, width of each requester data word and of the output word.
- MAX_BURST, 4, maximum beats transferred per grant before forced re-arbitration (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  4  bit i: requester i presents a valid beat.
- req_data0  input  DATA_LEN  requester 0 data (mux X0).
- req_data1  input  DATA_LEN  requester 1 data (mux X1).
- req_data2  input  DATA_LEN  requester 2 data (mux X2).
- req_data3  input  DATA_LEN  requester 3 data (mux X3).
- req_ready  output  4  bit i: beat from requester i accepted this cycle when req_valid[i] is also high.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_LEN  output beat data (mux F).
- out_ready  input  1  consumer accepts beat.
- out_sel  output  2  current grant index (mux Y), registered.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (rst_n low, async; takes effect immediately, no clock needed):
  - state=IDLE, out_sel=2'b00, last_grant=2'b11 (so requester 0 has first priority), beat_cnt=0.
  - Outputs while in reset: busy=0, out_valid=0, req_ready=4'b0000, out_data=0.
  - Reset mid-burst aborts the grant; no beat is reported accepted in that cycle.
- States: IDLE, BUSY.
- IDLE:
  - out_valid=0, req_ready=0, out_data=0, busy=0.
  - If req_valid != 0, choose the winner with rotating priority: the first i with req_valid[i]=1, scanning last_grant+1, +2, +3, +4 (mod 4).
  - On the next edge: out_sel=winner, beat_cnt=0, state=BUSY.
  - Grant latency: 1 cycle from a request being sampled in IDLE to busy=1.
- BUSY (combinational pass-through through the mux, select = registered out_sel):
  - out_valid = req_valid[out_sel].
  - out_data = req_data[out_sel].
  - req_ready[out_sel] = out_ready; all other req_ready bits are 0.
  - busy=1.
  - Transfer = out_valid & out_ready; on a transfer, beat_cnt increments (4-bit, saturates, never wraps).
  - Release on the edge where either holds:
    - (a) a transfer occurs with beat_cnt == MAX_BURST-1;
    - (b) req_valid[out_sel]=0 (requester idle between beats).
  - On release: last_grant=out_sel, beat_cnt=0, state=IDLE. The IDLE cycle after a release is mandatory; there are no back-to-back grants without it.
- Fairness:
  - A requester holding continuous valid gets at most MAX_BURST beats per grant.
  - With all four requesting, grant order is 0,1,2,3,0,...
- Simultaneous events:
  - A new req_valid rising on a non-granted port during BUSY is ignored until the next IDLE.
  - Release (a) and (b) cannot coincide, since (a) requires valid=1.
  - out_ready low stalls: no count change, no release under (a).
- Protocol rules:
  - Requesters must hold req_data stable while req_valid=1 and req_ready=0. The block does not check this.
  - Dropping req_valid without a transfer is legal and triggers release (b).
- Stability: out_sel changes only on the IDLE->BUSY edge; it holds its value through IDLE.
- MAX_BURST=1: every transfer releases.

Test Plan:
- Reset, then req_valid=4'b0001, req_data0=2'b10, out_ready=1.
  - Required: cycle 1 busy=1, out_sel=0, out_data=2'b10, req_ready=4'b0001.
  - After 4 beats: release; 1 IDLE cycle; re-grant 0.
- req_valid=4'b1111 constantly, out_ready=1, MAX_BURST=4.
  - Required: grants 0,1,2,3,0 in order.
  - Each grant is 4 beats with out_data equal to that port's data, followed by 1 IDLE cycle. Period is 20 cycles.
- Grant to 2, out_ready=0 for 3 cycles.
  - Required: out_valid=1, beat_cnt unchanged, req_ready=0, no release.
  - Then out_ready=1: 4 beats complete.
- Grant to 1, drop req_valid[1] after 2 beats while req_valid[3]=1.
  - Required: release next edge, IDLE 1 cycle, then out_sel=3.
- Assert rst_n=0 mid-burst on port 2.
  - Required: immediately busy=0, out_valid=0, req_ready=0.
  - After release with req_valid=4'b0100: grant to 2 (priority restarts at 0, and 0/1 are idle).
- MAX_BURST=1 build, req_valid=4'b0101.
  - Required: alternating single beats 0,2,0,2, each separated by 1 IDLE cycle.
